spi_slave_regfile: RTL and testbench

SPI slave that sits directly downstream of spi_master on the MOSI/SCLK/CS/MISO pins. It oversamples the bus in the system clock domain and decodes a command byte followed by data bytes. It writes to or reads from a small register file and returns read data on MISO. The register outputs drive the peripheral logic behind the link (LEDs, FND, control bits).

---
 rtl/spi_pkg.sv | 23 ++
 rtl/spi_sync.sv | 40 ++++
 rtl/spi_slave_regfile.sv | 185 ++++++++++++++++++
 tb/tb_spi_slave_regfile.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave register file.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    WR   = 2'd2,
    RD   = 2'd3
  } state_e;

  // Command byte: bit 7 selects write (1) or read (0).
  localparam int   CMD_RW_BIT = 7;
  localparam logic CMD_WRITE  = 1'b1;

  // SPI modes encoded as {CPOL,CPHA}.
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_sync.sv
// N-stage synchronizer for one asynchronous pin plus registered rise/fall detect.
// Latency: pin change visible on q_o/rise_o/fall_o after N clk; acted on at clk N+1.
// Backpressure: none; free-running sampler.
//
// Ports:
//   clk, reset     system clock, async active-low reset
//   d_i            asynchronous pin
//   q_o            synchronized level
//   rise_o/fall_o  one-clk pulses on synchronized level change
// N must be at least 2.
module spi_sync #(
  parameter int   N       = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [N-1:0] sync_q;
  logic         prev_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= {N{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[N-2:0], d_i};
      prev_q <= sync_q[N-1];
    end
  end

  assign q_o    = sync_q[N-1];
  assign rise_o = sync_q[N-1] & ~prev_q;
  assign fall_o = ~sync_q[N-1] & prev_q;

endmodule

// File: rtl/spi_slave_regfile.sv
// SPI slave decoding a command byte then data bytes into an 8-bit register file.
// Latency: pin-to-action SYNC_STAGES+1 clk; reg_out/wr_strobe 1 clk after byte completion.
// Backpressure: none; master paces the link, SCLK half-period >= SYNC_STAGES+2 clk.
//
// Ports:
//   clk, reset              system clock, async active-low reset
//   MODE                    {CPOL,CPHA}, captured at frame start
//   SCLK, MOSI, CS          SPI pins from master (async), MISO to master
//   reg_out                 flattened registers, reg i at [8i+7:8i]
//   wr_strobe/addr/data     one pulse per completed register write
//   rx_byte, rx_valid       last received byte and its update pulse
//   busy                    frame in progress
module spi_slave_regfile #(
  parameter int NUM_REGS    = 4,
  parameter int ADDR_W      = $clog2(NUM_REGS),
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            MODE,
  input  logic                  SCLK,
  input  logic                  MOSI,
  input  logic                  CS,
  output logic                  MISO,
  output logic [NUM_REGS*8-1:0] reg_out,
  output logic                  wr_strobe,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [7:0]            wr_data,
  output logic [7:0]            rx_byte,
  output logic                  rx_valid,
  output logic                  busy
);
  import spi_pkg::*;

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic mosi_s, mosi_rise, mosi_fall;
  logic cs_lvl, cs_rise, cs_fall;

  spi_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk(clk), .reset(reset), .d_i(SCLK), .q_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall));
  spi_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
    .clk(clk), .reset(reset), .d_i(MOSI), .q_o(mosi_s), .rise_o(mosi_rise), .fall_o(mosi_fall));
  // CS idles high, so its synchronizer resets high to avoid a spurious frame start.
  spi_sync #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .clk(clk), .reset(reset), .d_i(CS), .q_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall));

  logic unused_sync;
  assign unused_sync = &{1'b0, sclk_lvl, mosi_rise, mosi_fall, cs_lvl};

  state_e            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        rx_shift_q, rx_shift_d;
  logic [7:0]        tx_shift_q, tx_shift_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        rx_byte_q, rx_byte_d;
  logic              rx_valid_q, rx_valid_d;
  logic              wr_strobe_q, wr_strobe_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              reg_we;
  logic [7:0]        regs_q [NUM_REGS];

  logic              sample_edge, shift_edge;
  logic [7:0]        byte_w;
  logic [ADDR_W-1:0] addr_nxt;

  // Modes 0 and 3 sample on rising SCLK, modes 1 and 2 on falling.
  assign sample_edge = (mode_q[1] ^ mode_q[0]) ? sclk_fall : sclk_rise;
  assign shift_edge  = (mode_q[1] ^ mode_q[0]) ? sclk_rise : sclk_fall;
  assign byte_w      = {rx_shift_q[6:0], mosi_s};
  assign addr_nxt    = addr_q + ADDR_W'(1);

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    addr_d      = addr_q;
    rx_byte_d   = rx_byte_q;
    rx_valid_d  = 1'b0;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    reg_we      = 1'b0;

    if (cs_rise) begin
      // End of frame has priority over a coincident sample edge.
      state_d    = IDLE;
      bit_cnt_d  = 3'd0;
      tx_shift_d = 8'h00;
    end else if (state_q == IDLE) begin
      if (cs_fall) begin
        state_d    = CMD;
        mode_d     = MODE;
        bit_cnt_d  = 3'd0;
        rx_shift_d = 8'h00;
        tx_shift_d = 8'h00;
      end
    end else if (sample_edge) begin
      rx_shift_d = byte_w;
      bit_cnt_d  = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        rx_byte_d  = byte_w;
        rx_valid_d = 1'b1;
        unique case (state_q)
          CMD: begin
            addr_d = byte_w[ADDR_W-1:0];
            if (byte_w[CMD_RW_BIT] == CMD_WRITE) begin
              state_d = WR;
            end else begin
              state_d    = RD;
              tx_shift_d = regs_q[byte_w[ADDR_W-1:0]];
            end
          end
          WR: begin
            reg_we      = 1'b1;
            wr_strobe_d = 1'b1;
            wr_addr_d   = addr_q;
            wr_data_d   = byte_w;
            addr_d      = addr_nxt;
          end
          RD: begin
            addr_d     = addr_nxt;
            tx_shift_d = regs_q[addr_nxt];
          end
          default: ;
        endcase
      end
    end else if (shift_edge && bit_cnt_q != 3'd0) begin
      // No shift at bit 0 keeps a freshly loaded MSB on the wire in both CPHA phases.
      tx_shift_d = {tx_shift_q[6:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      mode_q      <= MODE0;
      bit_cnt_q   <= 3'd0;
      rx_shift_q  <= 8'h00;
      tx_shift_q  <= 8'h00;
      addr_q      <= '0;
      rx_byte_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      addr_q      <= addr_d;
      rx_byte_q   <= rx_byte_d;
      rx_valid_q  <= rx_valid_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 8'h00;
    end else if (reg_we) begin
      regs_q[addr_q] <= byte_w;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
    assign reg_out[8*g +: 8] = regs_q[g];
  end

  assign busy      = (state_q != IDLE);
  assign MISO      = busy ? tx_shift_q[7] : 1'b0;
  assign rx_byte   = rx_byte_q;
  assign rx_valid  = rx_valid_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Scoreboard bench for spi_slave_regfile driven by a bit-level SPI master model.
// Latency: n/a.
// Backpressure: n/a.
module tb_spi_slave_regfile;
  localparam int NR = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    MODE;
  logic          SCLK, MOSI, CS;
  logic          MISO;
  logic [NR*8-1:0] reg_out;
  logic          wr_strobe;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic [7:0]    rx_byte;
  logic          rx_valid;
  logic          busy;

  spi_slave_regfile #(.NUM_REGS(NR), .ADDR_W(AW), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .MODE(MODE), .SCLK(SCLK), .MOSI(MOSI), .CS(CS),
    .MISO(MISO), .reg_out(reg_out), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
    .wr_data(wr_data), .rx_byte(rx_byte), .rx_valid(rx_valid), .busy(busy));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [7:0]    d;
  } wr_t;

  int         checks = 0;
  int         errors = 0;
  wr_t        exp_wr[$];
  logic [7:0] exp_rx[$];
  logic [7:0] exp_miso[$];
  logic [7:0] miso_got[$];
  logic [7:0] frm[$];
  logic [7:0] model[NR];
  wr_t        mon_w;
  logic [7:0] mon_r;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [NR*8-1:0] model_flat();
    logic [NR*8-1:0] f;
    for (int i = 0; i < NR; i++) f[8*i +: 8] = model[i];
    return f;
  endfunction

  // Write and receive monitors: pop the oldest expectation whenever the DUT reports one.
  always @(negedge clk) begin
    if (wr_strobe) begin
      if (exp_wr.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wr_unexpected got addr=%0d data=%0h, none expected", wr_addr, wr_data);
      end else begin
        mon_w = exp_wr.pop_front();
        chk("wr_addr", 64'(wr_addr), 64'(mon_w.a));
        chk("wr_data", 64'(wr_data), 64'(mon_w.d));
        chk("reg_out_at_strobe", 64'(reg_out[8*mon_w.a +: 8]), 64'(mon_w.d));
      end
    end
    if (rx_valid) begin
      if (exp_rx.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx_unexpected got byte=%0h, none expected", rx_byte);
      end else begin
        mon_r = exp_rx.pop_front();
        chk("rx_byte", 64'(rx_byte), 64'(mon_r));
      end
    end
  end

  // Reference model of one frame: queues expected bytes, writes and MISO data.
  // part_bits>0 truncates the last byte; coincide raises CS on its last sample edge.
  task automatic prep_frame(input int part_bits, input bit coincide);
    int n     = frm.size();
    int nfull = n - ((part_bits > 0 || coincide) ? 1 : 0);
    int nmiso = n - ((part_bits > 0) ? 1 : 0);
    logic [7:0] cmd = frm[0];
    int a = cmd % NR;
    for (int i = 0; i < nfull; i++) exp_rx.push_back(frm[i]);
    exp_miso.delete();
    if (nmiso >= 1) exp_miso.push_back(8'h00);
    for (int i = 1; i < nmiso; i++) begin
      if (cmd >= 8'h80) begin
        exp_miso.push_back(8'h00);
        if (i < nfull) begin
          model[a] = frm[i];
          exp_wr.push_back({AW'(a), frm[i]});
        end
      end else begin
        exp_miso.push_back(model[a]);
      end
      a = (a + 1) % NR;
    end
  endtask

  task automatic run_frame(input logic [1:0] mode, input int hp, input int part_bits,
                           input bit coincide, input bit no_end);
    int n = frm.size();
    logic [7:0] cur;
    logic [7:0] cap;
    int nb;
    bit lastedge;
    MODE = mode;
    SCLK = mode[1];
    MOSI = 1'b0;
    wait_clks(hp + 4);
    CS = 1'b0;
    wait_clks(hp);
    chk("busy_in_frame", 64'(busy), 64'(1));
    MODE = 2'($urandom);
    miso_got.delete();
    for (int i = 0; i < n; i++) begin
      cur = frm[i];
      nb  = (i == n - 1 && part_bits > 0) ? part_bits : 8;
      cap = 8'h00;
      for (int k = 0; k < nb; k++) begin
        lastedge = coincide && (i == n - 1) && (k == 7);
        if (!mode[0]) begin
          MOSI = cur[7-k];
          wait_clks(hp);
          cap  = {cap[6:0], MISO};
          SCLK = ~mode[1];
          if (lastedge) CS = 1'b1;
          wait_clks(hp);
          SCLK = mode[1];
        end else begin
          SCLK = ~mode[1];
          MOSI = cur[7-k];
          wait_clks(hp);
          cap  = {cap[6:0], MISO};
          SCLK = mode[1];
          if (lastedge) CS = 1'b1;
          wait_clks(hp);
        end
      end
      if (nb == 8) miso_got.push_back(cap);
    end
    if (!no_end) begin
      wait_clks(hp);
      CS = 1'b1;
    end
    wait_clks(hp + 4);
    chk("miso_count", 64'(miso_got.size()), 64'(exp_miso.size()));
    for (int i = 0; i < miso_got.size() && i < exp_miso.size(); i++)
      chk("miso_byte", 64'(miso_got[i]), 64'(exp_miso[i]));
    if (!no_end) begin
      chk("busy_after_frame", 64'(busy), 64'(0));
      chk("miso_after_frame", 64'(MISO), 64'(0));
      chk("reg_out_after_frame", 64'(reg_out), 64'(model_flat()));
    end
  endtask

  task automatic frame(input logic [1:0] mode, input int hp, input int part_bits, input bit coincide);
    prep_frame(part_bits, coincide);
    run_frame(mode, hp, part_bits, coincide, 1'b0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_reg_out"}, 64'(reg_out), 64'(0));
    chk({nm, "_miso"}, 64'(MISO), 64'(0));
    chk({nm, "_wr_strobe"}, 64'(wr_strobe), 64'(0));
    chk({nm, "_wr_addr"}, 64'(wr_addr), 64'(0));
    chk({nm, "_wr_data"}, 64'(wr_data), 64'(0));
    chk({nm, "_rx_byte"}, 64'(rx_byte), 64'(0));
    chk({nm, "_rx_valid"}, 64'(rx_valid), 64'(0));
    chk({nm, "_busy"}, 64'(busy), 64'(0));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int len;
    int pb;
    bit co;
    reset = 1'b0;
    CS    = 1'b1;
    SCLK  = 1'b0;
    MOSI  = 1'b0;
    MODE  = 2'b00;
    for (int i = 0; i < NR; i++) model[i] = 8'h00;
    wait_clks(5);
    chk_all_zero("reset");
    reset = 1'b1;
    wait_clks(5);

    // Mode 0 slow: write with address wrap, then preload and read back with wrap.
    frm = '{8'h81, 8'h11, 8'h22, 8'h33, 8'h44};
    frame(2'b00, 50, 0, 1'b0);
    frm = '{8'h80, 8'hA0, 8'hB1, 8'hC2, 8'hD3};
    frame(2'b00, 50, 0, 1'b0);
    frm = '{8'h02, 8'h00, 8'h00, 8'h00};
    frame(2'b00, 50, 0, 1'b0);

    // Same scenarios at minimum half-period in the other modes.
    for (int m = 1; m < 4; m++) begin
      frm = '{8'h81, 8'h11, 8'h22, 8'h33, 8'h44};
      frame(2'(m), 4, 0, 1'b0);
      frm = '{8'h80, 8'hA0, 8'hB1, 8'hC2, 8'hD3};
      frame(2'(m), 4, 0, 1'b0);
      frm = '{8'h02, 8'h00, 8'h00, 8'h00};
      frame(2'(m), 4, 0, 1'b0);
    end

    // Abort after 5 bits of a data byte, then a clean read frame.
    frm = '{8'h81, 8'h77, 8'h99};
    frame(2'b00, 6, 5, 1'b0);
    frm = '{8'h01, 8'h00, 8'h00, 8'h00};
    frame(2'b00, 6, 0, 1'b0);

    // CS rising together with the 8th sample edge of the last byte.
    frm = '{8'h82, 8'h3C, 8'hE7};
    frame(2'b00, 5, 0, 1'b1);
    frm = '{8'h81, 8'h5E, 8'h6F};
    frame(2'b11, 5, 0, 1'b1);

    // Reset in the middle of a read frame, then a fresh write.
    frm = '{8'h01, 8'hFF};
    prep_frame(4, 1'b0);
    run_frame(2'b00, 5, 4, 1'b0, 1'b1);
    chk("busy_before_reset", 64'(busy), 64'(1));
    reset = 1'b0;
    wait_clks(2);
    chk_all_zero("mid_reset");
    CS   = 1'b1;
    SCLK = 1'b0;
    wait_clks(3);
    reset = 1'b1;
    for (int i = 0; i < NR; i++) model[i] = 8'h00;
    wait_clks(4);
    frm = '{8'h80, 8'h5A};
    frame(2'b00, 5, 0, 1'b0);

    // Randomized frames against the model.
    for (int t = 0; t < 30; t++) begin
      len = $urandom_range(2, 5);
      b = 8'($urandom);
      if ($urandom_range(0, 1) == 1) b[7] = 1'b1;
      else b[7] = 1'b0;
      frm.delete();
      frm.push_back(b);
      for (int i = 1; i < len; i++) frm.push_back(8'($urandom));
      pb = 0;
      co = 1'b0;
      if ($urandom_range(0, 4) == 0) pb = $urandom_range(1, 7);
      else if ($urandom_range(0, 5) == 0) co = 1'b1;
      frame(2'($urandom), $urandom_range(4, 8), pb, co);
    end

    wait_clks(10);
    chk("wr_queue_drained", 64'(exp_wr.size()), 64'(0));
    chk("rx_queue_drained", 64'(exp_rx.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
